serial_char_receiver: RTL and testbench
=======================================

// Module: serial_char_receiver
// PURPOSE
//  UART-style 8N1 serial receiver that feeds the character_recognition stage.
//  Deserialises the rx line into bytes and optionally folds lowercase to uppercase.
//  Presents each byte on char for exactly one clock; char is 8'h00 (NUL) at all
//  other times, so downstream sees one symbol per received character.
//  Sits directly upstream: its char output wires to the recogniser's char input.
// PARAMETERS
//  CLKS_PER_BIT  16  clocks per serial bit; must be >= 4; mid-bit sample point = CLKS_PER_BIT/2
//  FOLD_CASE     1   1: map 8'h61..8'h7A ('a'..'z') to 8'h41..8'h5A; 0: pass bytes unchanged
// PORTS
//  clock          input   1  system clock; all state changes on rising edge
//  reset          input   1  asynchronous, active-low reset
//  rx             input   1  asynchronous serial line; idle high, LSB first
//  char           output  8  received byte for one cycle, else 8'h00
//  char_valid     output  1  one-cycle pulse aligned with char
//  framing_error  output  1  one-cycle pulse when the stop bit samples low
//  busy           output  1  high while state != IDLE
// BEHAVIOUR
//  Reset (reset==0): state=IDLE; counters=0; sync flops=1; char=8'h00;
//   char_valid=0; framing_error=0; busy=0. Takes effect immediately, mid-frame included.
//   A partial frame is discarded; after release, wait for a fresh falling edge.
//  rx passes through a 2-flop synchroniser (rx_s). All decisions use rx_s only.
//  FSM states: IDLE, START, DATA, STOP.
//   IDLE : on rx_s==0 -> START, clk_cnt=0.
//   START: at clk_cnt==CLKS_PER_BIT/2-1 sample rx_s. 0 -> DATA, clk_cnt=0, bit_cnt=0.
//          1 -> IDLE (false start/glitch); no output.
//   DATA : at clk_cnt==CLKS_PER_BIT-1 shift rx_s into shreg[bit_cnt], LSB first; clk_cnt=0.
//          After bit_cnt==7 -> STOP.
//   STOP : at clk_cnt==CLKS_PER_BIT-1 sample rx_s, then -> IDLE in the same edge.
//          1 -> next cycle char=fold(shreg) and char_valid=1.
//          0 -> next cycle framing_error=1; char stays 8'h00.
//  Outputs are registered. Output latency is 1 clock after the stop-bit sample.
//   Line-to-sample latency adds 2 clocks for the synchroniser.
//  char and char_valid revert to 8'h00 / 0 on the following clock; no holding.
//  Back-to-back frames: the return to IDLE at mid-stop allows a start bit that
//   immediately follows the stop bit to be detected. No byte is lost at full line rate.
//  rx held low permanently: START->DATA->STOP produces framing_error.
//   FSM then re-enters START from IDLE only after rx_s returns high and falls again.
//   IDLE additionally requires rx_s to have been 1 for at least one cycle.
//  clk_cnt width = $clog2(CLKS_PER_BIT); bit_cnt is 3 bits; both wrap only under FSM control.
//  Received byte 8'h00 still pulses char_valid, with char=8'h00.
//  fold(): FOLD_CASE and 8'h61<=b<=8'h7A -> b-8'h20; otherwise b.
// STRUCTURE
//  Shared package char_pkg: FSM state localparams (IDLE/START/DATA/STOP, 2-bit)
//   and ASCII constants (ASCII_NUL=8'h00, ASCII_LC_A=8'h61, ASCII_LC_Z=8'h7A,
//   CASE_OFFSET=8'h20). The recogniser reuses the package for its letter constants.
//  One sub-module: sync_2ff. 2-flop synchroniser with async active-low reset to 1.
//  The FSM, counters, shift register and output register stay in this module.
// TESTING (CLKS_PER_BIT=4, FOLD_CASE=1, clock period 20)
//  1. Frame 8'h52 ('R') with stop=1 -> exactly one cycle with char=8'h52 and char_valid=1.
//     char=8'h00 before and after; framing_error never asserts.
//  2. Frame 8'h72 ('r') -> char=8'h52 for one cycle. With FOLD_CASE=0, char=8'h72.
//  3. Send "RUN" (8'h52, 8'h55, 8'h4E) with no idle gap -> three single-cycle pulses.
//     Pulses are spaced 40 clocks apart, values in order; feeding character_recognition
//     then asserts start_car.
//  4. rx low for 1 clock, then high -> no char_valid, no framing_error; FSM back in IDLE by START sample.
//  5. Frame 8'h41 with stop bit 0 -> framing_error pulses once; char_valid never asserts.
//     A following valid 8'h42 is then received correctly.
//  6. Assert reset during DATA bit 4 of 8'h43, then release with rx high -> all outputs 0 immediately.
//     No char is output for the aborted frame; the next full 8'h44 frame yields char=8'h44.

Source files
------------

// File: rtl/char_pkg.sv
// Shared constants for the serial receiver and the downstream character recogniser:
// receiver FSM state encoding, ASCII constants and the case-folding helper.
package char_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

    localparam logic [7:0] ASCII_NUL   = 8'h00;
    localparam logic [7:0] ASCII_LC_A  = 8'h61;
    localparam logic [7:0] ASCII_LC_Z  = 8'h7A;
    localparam logic [7:0] CASE_OFFSET = 8'h20;

    function automatic logic [7:0] fold(input logic [7:0] b, input logic enable);
        if (enable && (b >= ASCII_LC_A) && (b <= ASCII_LC_Z)) begin
            return b - CASE_OFFSET;
        end
        return b;
    endfunction

endpackage

// File: rtl/serial_char_receiver_sync_2ff.sv
// Two-flop synchroniser for the asynchronous rx line; resets to the idle-high level
// so no false start bit is seen on reset release.
module sync_2ff (
    input  logic clock,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // NOTE: sequential state uses non-blocking assignments so both flops sample the
    // pre-edge values and the chain really is two stages deep.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/serial_char_receiver.sv
// 8N1 serial receiver: deserialises rx into bytes, optionally folds lowercase to
// uppercase, and presents each byte on char_o for exactly one clock (NUL otherwise).
module serial_char_receiver
    import char_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter bit FOLD_CASE    = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] char_o,
    output logic       char_valid,
    output logic       framing_error,
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    rx_state_e     state_q;
    logic [CW-1:0] clk_cnt_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shreg_q;
    logic          rx_s;
    logic          rx_prev_q;
    logic [7:0]    char_q;
    logic          char_valid_q;
    logic          framing_error_q;

    sync_2ff u_sync (
        .clock (clock),
        .reset (reset),
        .d_i   (rx),
        .q_o   (rx_s)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            clk_cnt_q       <= '0;
            bit_cnt_q       <= '0;
            shreg_q         <= '0;
            rx_prev_q       <= 1'b1;
            char_q          <= ASCII_NUL;
            char_valid_q    <= 1'b0;
            framing_error_q <= 1'b0;
        end else begin
            rx_prev_q       <= rx_s;
            char_q          <= ASCII_NUL;
            char_valid_q    <= 1'b0;
            framing_error_q <= 1'b0;

            case (state_q)
                // Only a genuine high-to-low transition starts a frame, so a line
                // stuck low after a framing error cannot retrigger reception.
                IDLE: begin
                    if (!rx_s && rx_prev_q) begin
                        state_q   <= START;
                        clk_cnt_q <= '0;
                    end
                end

                START: begin
                    if (clk_cnt_q == HALF_LAST) begin
                        clk_cnt_q <= '0;
                        bit_cnt_q <= '0;
                        state_q   <= rx_s ? IDLE : DATA;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end

                DATA: begin
                    if (clk_cnt_q == BIT_LAST) begin
                        clk_cnt_q          <= '0;
                        shreg_q[bit_cnt_q] <= rx_s;
                        bit_cnt_q          <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= STOP;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end

                // Leaving at mid-stop gives half a bit of slack to catch a start
                // bit that immediately follows.
                STOP: begin
                    if (clk_cnt_q == BIT_LAST) begin
                        clk_cnt_q <= '0;
                        state_q   <= IDLE;
                        if (rx_s) begin
                            char_q       <= fold(shreg_q, FOLD_CASE);
                            char_valid_q <= 1'b1;
                        end else begin
                            framing_error_q <= 1'b1;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign char_o        = char_q;
    assign char_valid    = char_valid_q;
    assign framing_error = framing_error_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_serial_char_receiver.sv
// Scoreboard bench for serial_char_receiver: one folding and one non-folding instance
// share the rx line; monitors pop expected events whenever an output pulse appears.
module tb_serial_char_receiver;

    localparam int CPB = 4;

    typedef enum int {EV_CHAR, EV_FERR} ev_kind_e;
    typedef struct {
        ev_kind_e   kind;
        logic [7:0] data;
    } ev_t;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] char_f;
    logic       valid_f;
    logic       ferr_f;
    logic       busy_f;
    logic [7:0] char_n;
    logic       valid_n;
    logic       ferr_n;
    logic       busy_n;

    int checks;
    int errors;
    int cyc;
    ev_t exp_f_q[$];
    ev_t exp_n_q[$];
    int  valid_cyc_q[$];

    serial_char_receiver #(.CLKS_PER_BIT(CPB), .FOLD_CASE(1'b1)) dut (
        .clock         (clk),
        .reset         (rst_n),
        .rx            (rx),
        .char_o        (char_f),
        .char_valid    (valid_f),
        .framing_error (ferr_f),
        .busy          (busy_f)
    );

    serial_char_receiver #(.CLKS_PER_BIT(CPB), .FOLD_CASE(1'b0)) dut_nf (
        .clock         (clk),
        .reset         (rst_n),
        .rx            (rx),
        .char_o        (char_n),
        .char_valid    (valid_n),
        .framing_error (ferr_n),
        .busy          (busy_n)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor for the case-folding instance.
    always @(negedge clk) begin
        ev_t ev;
        if (rst_n) begin
            if (valid_f || ferr_f) begin
                if (exp_f_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL fold_unexpected_event: got char=%0h valid=%0b ferr=%0b, expected nothing",
                             char_f, valid_f, ferr_f);
                end else begin
                    ev = exp_f_q.pop_front();
                    check("fold_kind", {30'd0, ferr_f, valid_f}, (ev.kind == EV_CHAR) ? 32'd1 : 32'd2);
                    check("fold_char", {24'd0, char_f}, {24'd0, ev.data});
                    if (valid_f) valid_cyc_q.push_back(cyc);
                end
            end else begin
                check("fold_idle_nul", {24'd0, char_f}, 32'd0);
            end
        end
    end

    // Monitor for the pass-through instance.
    always @(negedge clk) begin
        ev_t ev;
        if (rst_n) begin
            if (valid_n || ferr_n) begin
                if (exp_n_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL raw_unexpected_event: got char=%0h valid=%0b ferr=%0b, expected nothing",
                             char_n, valid_n, ferr_n);
                end else begin
                    ev = exp_n_q.pop_front();
                    check("raw_kind", {30'd0, ferr_n, valid_n}, (ev.kind == EV_CHAR) ? 32'd1 : 32'd2);
                    check("raw_char", {24'd0, char_n}, {24'd0, ev.data});
                end
            end else begin
                check("raw_idle_nul", {24'd0, char_n}, 32'd0);
            end
        end
    end

    task automatic send_bit(input logic b);
        rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic idle_bits(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b1);
    endtask

    // Pushes hand-computed expectations for both instances, then drives the frame.
    task automatic send_frame(input logic [7:0] data, input logic stop_ok,
                              input logic [7:0] exp_fold, input logic [7:0] exp_raw);
        ev_t ef;
        ev_t en;
        ef.kind = stop_ok ? EV_CHAR : EV_FERR;
        en.kind = ef.kind;
        ef.data = stop_ok ? exp_fold : 8'h00;
        en.data = stop_ok ? exp_raw : 8'h00;
        exp_f_q.push_back(ef);
        exp_n_q.push_back(en);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(data[i]);
        send_bit(stop_ok);
    endtask

    task automatic check_all_outputs_zero(input string tag);
        check({tag, "_char"}, {24'd0, char_f}, 32'd0);
        check({tag, "_valid"}, {31'd0, valid_f}, 32'd0);
        check({tag, "_ferr"}, {31'd0, ferr_f}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy_f}, 32'd0);
        check({tag, "_raw_busy"}, {31'd0, busy_n}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [7:0] aborted;
        checks  = 0;
        errors  = 0;
        cyc     = 0;
        rst_n   = 1'b0;
        rx      = 1'b1;
        aborted = 8'h43;

        repeat (2) @(negedge clk);
        #1 check_all_outputs_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // 'R' passes through unchanged.
        send_frame(8'h52, 1'b1, 8'h52, 8'h52);
        idle_bits(2);

        // 'r' folds to 'R' only on the folding instance.
        send_frame(8'h72, 1'b1, 8'h52, 8'h72);
        idle_bits(2);

        // "RUN" at full line rate: pulses 40 clocks apart.
        base = valid_cyc_q.size();
        send_frame(8'h52, 1'b1, 8'h52, 8'h52);
        send_frame(8'h55, 1'b1, 8'h55, 8'h55);
        send_frame(8'h4E, 1'b1, 8'h4E, 8'h4E);
        idle_bits(2);
        check("run_pulse_count", valid_cyc_q.size(), base + 3);
        if (valid_cyc_q.size() == base + 3) begin
            check("run_spacing_1", valid_cyc_q[base + 1] - valid_cyc_q[base], 32'd40);
            check("run_spacing_2", valid_cyc_q[base + 2] - valid_cyc_q[base + 1], 32'd40);
        end

        // Fold boundaries and NUL byte, back to back.
        send_frame(8'h61, 1'b1, 8'h41, 8'h61);
        send_frame(8'h7A, 1'b1, 8'h5A, 8'h7A);
        send_frame(8'h60, 1'b1, 8'h60, 8'h60);
        send_frame(8'h7B, 1'b1, 8'h7B, 8'h7B);
        send_frame(8'h00, 1'b1, 8'h00, 8'h00);
        idle_bits(2);

        // One-clock glitch: false start, no output.
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        idle_bits(2);
        check("glitch_busy_idle", {31'd0, busy_f}, 32'd0);

        // Bad stop bit, then a good frame.
        send_frame(8'h41, 1'b0, 8'h00, 8'h00);
        idle_bits(2);
        send_frame(8'h42, 1'b1, 8'h42, 8'h42);
        idle_bits(2);

        // Reset during data bit 4 of 'C'; the aborted frame produces nothing.
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(aborted[i]);
        rx = aborted[4];
        repeat (2) @(negedge clk);
        check("abort_busy_before_reset", {31'd0, busy_f}, 32'd1);
        #5 rst_n = 1'b0;
        rx = 1'b1;
        #1 check_all_outputs_zero("abort_reset");
        @(negedge clk);
        #5 rst_n = 1'b1;
        idle_bits(3);
        check("abort_busy_after", {31'd0, busy_f}, 32'd0);
        send_frame(8'h44, 1'b1, 8'h44, 8'h44);
        idle_bits(3);

        check("fold_queue_drained", exp_f_q.size(), 32'd0);
        check("raw_queue_drained", exp_n_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
